wdrc_compressor_stage: RTL

//  Wide-dynamic-range compressor stage fed directly by spectral_subtraction_stage
//  (its audio_out/audio_ready drive audio_in/audio_valid here). Each sample passes through:
//  - an attack/release envelope follower;
//  - a compression gain computed above a threshold by a 13-step sequential divider;
//  - a makeup gain, then saturation.
//  It returns one processed sample per accepted input, at a fixed latency.

---
 rtl/wdrc_compressor_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/wdrc_compressor_stage.sv
// Wide-dynamic-range compressor stage: envelope follower, knee/ratio gain via
// a 13-step restoring divider, makeup gain, 16-bit saturation.
// Optional output limiter enabled by defining WDRC_LIMITER_EN.
//
// state | meaning
// IDLE  | waiting for audio_valid; captures sample and config
// ENV   | phase 0: envelope update; phase 1: target level, divider load
// DIV   | one quotient bit per cycle, bits 12..0
// GAIN  | total gain t = g * makeup, clamped to 16 bits
// APPLY | y = x * t, saturate, publish audio_out/gain_out, pulse audio_ready
module wdrc_compressor_stage #(
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8,
  parameter int LIMIT_LEVEL   = 30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_in,
  input  logic        audio_valid,
  input  logic [15:0] threshold,
  input  logic [2:0]  ratio_shift,
  input  logic [15:0] makeup_gain,
  output logic [15:0] audio_out,
  output logic        audio_ready,
  output logic [15:0] gain_out,
  output logic        busy,
  output logic        drop_flag
);

`ifdef WDRC_LIMITER_EN
  localparam bit LIMITER_ON = 1'b1;
`else
  localparam bit LIMITER_ON = 1'b0;
`endif

  // Without the limiter the clamp bounds equal the 16-bit rails and never bite.
  localparam logic signed [15:0] LIM_HI = LIMITER_ON ? 16'(LIMIT_LEVEL)  : 16'sh7FFF;
  localparam logic signed [15:0] LIM_LO = LIMITER_ON ? 16'(-LIMIT_LEVEL) : 16'sh8000;
  localparam logic signed [32:0] SAT_HI = 33'sd32767;
  localparam logic signed [32:0] SAT_LO = -33'sd32768;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENV   = 3'd1,
    ST_DIV   = 3'd2,
    ST_GAIN  = 3'd3,
    ST_APPLY = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        env_ph_q;
  logic [15:0] x_q, thr_q, mk_q, env_q, t_q;
  logic [2:0]  rs_q;
  logic [27:0] rem_q, dsh_q;
  logic [12:0] quo_q;
  logic [3:0]  cnt_q;
  logic        bypass_q;
  logic [15:0] audio_out_q, gain_out_q;
  logic        audio_ready_q, drop_q;

  logic [15:0] mag, env_new, tgt;
  logic        rem_ge;
  logic [12:0] g;
  logic [28:0] gm, gm_sh;
  logic [15:0] t_new;
  logic signed [32:0] xs, ts, p, ysh;
  logic signed [15:0] ysat, ylim;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (audio_valid) state_d = ST_ENV;
      ST_ENV:   if (env_ph_q) state_d = ST_DIV;
      ST_DIV:   if (cnt_q == 4'd0) state_d = ST_GAIN;
      ST_GAIN:  state_d = ST_APPLY;
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Envelope follower, knee target and one divider step
  always_comb begin
    mag     = (x_q == 16'h8000) ? 16'h7FFF : (x_q[15] ? (16'd0 - x_q) : x_q);
    env_new = (mag > env_q) ? env_q + ((mag - env_q) >> ATTACK_SHIFT)
                            : env_q - ((env_q - mag) >> RELEASE_SHIFT);
    tgt     = (env_q > thr_q) ? thr_q + ((env_q - thr_q) >> rs_q) : env_q;
    rem_ge  = (rem_q >= dsh_q);
  end

  // Gain product and output scaling with saturation / limiting
  always_comb begin
    g     = bypass_q ? 13'h1000 : quo_q;
    gm    = {16'b0, g} * {13'b0, mk_q};
    gm_sh = gm >> 12;
    t_new = (|gm_sh[28:16]) ? 16'hFFFF : gm_sh[15:0];
    xs    = {{17{x_q[15]}}, x_q};
    ts    = {17'b0, t_q};
    p     = xs * ts;
    ysh   = p >>> 12;
    if (ysh > SAT_HI)      ysat = 16'sh7FFF;
    else if (ysh < SAT_LO) ysat = 16'sh8000;
    else                   ysat = ysh[15:0];
    ylim = ysat;
    if (ysat > LIM_HI)      ylim = LIM_HI;
    else if (ysat < LIM_LO) ylim = LIM_LO;
  end

  // Datapath registers sequenced by the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_ph_q      <= 1'b0;
      x_q           <= '0;
      thr_q         <= '0;
      rs_q          <= '0;
      mk_q          <= '0;
      env_q         <= '0;
      t_q           <= '0;
      rem_q         <= '0;
      dsh_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      bypass_q      <= 1'b1;
      audio_out_q   <= '0;
      gain_out_q    <= 16'h1000;
      audio_ready_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      audio_ready_q <= 1'b0;
      if (audio_valid && state_q != ST_IDLE) drop_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (audio_valid) begin
            x_q      <= audio_in;
            thr_q    <= threshold;
            rs_q     <= ratio_shift;
            mk_q     <= makeup_gain;
            env_ph_q <= 1'b0;
          end
        end
        ST_ENV: begin
          if (!env_ph_q) begin
            env_q    <= env_new;
            env_ph_q <= 1'b1;
          end else begin
            env_ph_q <= 1'b0;
            rem_q    <= {tgt, 12'b0};
            dsh_q    <= {env_q, 12'b0};
            quo_q    <= '0;
            cnt_q    <= 4'd12;
            bypass_q <= (env_q <= thr_q) || (env_q == 16'd0);
          end
        end
        ST_DIV: begin
          if (rem_ge) rem_q <= rem_q - dsh_q;
          quo_q <= {quo_q[11:0], rem_ge};
          dsh_q <= dsh_q >> 1;
          cnt_q <= cnt_q - 4'd1;
        end
        ST_GAIN: begin
          t_q <= t_new;
        end
        ST_APPLY: begin
          audio_out_q   <= ylim;
          gain_out_q    <= t_q;
          audio_ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign audio_out   = audio_out_q;
  assign audio_ready = audio_ready_q;
  assign gain_out    = gain_out_q;
  assign drop_flag   = drop_q;

endmodule
